// File: rtl/mem_wb_pkg.sv
// Shared types and default widths for the MEM/WB pipeline register.
// The latched-op struct is sized for the widest supported configuration.
package mem_wb_pkg;

    localparam int unsigned DefDataW   = 8;
    localparam int unsigned DefRegAw   = 3;
    localparam int unsigned DefMaxWait = 15;
    localparam int unsigned DefCntW    = 16;

    // Upper limits on DATA_W / REG_AW; narrower configs leave the top bits zero.
    localparam int unsigned MaxDataW = 32;
    localparam int unsigned MaxRegAw = 5;

    typedef enum logic [0:0] {
        StIdle,
        StMem
    } state_e;

    typedef struct packed {
        logic                regwrite;
        logic                mem_to_reg;
        logic                we;
        logic [MaxDataW-1:0] addr;
        logic [MaxDataW-1:0] wdata;
        logic [MaxRegAw-1:0] rd;
    } mem_op_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts MEM cycles without ack; timeout_o fires on the cycle whose edge
// would bring the count to MAX_WAIT.
module mem_wait_timer #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic timeout_o
);

    localparam int unsigned CntW = $clog2(MAX_WAIT + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(MAX_WAIT - 1);
    localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_WAIT);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != MaxCnt)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    assign timeout_o = enable_i && (cnt_q == LastCnt);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register: owns the data-memory req/ack transaction, selects the
// write-back source, aborts on timeout and counts retired instructions.
module mem_wb_pipe
    import mem_wb_pkg::*;
#(
    parameter int unsigned DATA_W             = DefDataW,
    parameter int unsigned REG_AW             = DefRegAw,
    parameter int unsigned MAX_WAIT           = DefMaxWait,
    parameter int unsigned CNT_W              = DefCntW,
    parameter int unsigned ZERO_REG_HARDWIRED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_regwrite,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_mem_to_reg,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_AW-1:0] ex_rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_regwrite,
    output logic [REG_AW-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              mem_err,
    output logic [CNT_W-1:0]  retired_cnt
);

    state_e  state_q, state_d;
    mem_op_t op_q, op_d, new_op;

    logic              wb_regwrite_q, wb_regwrite_d;
    logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    // Holds a non-memory op accepted in an ack cycle; the port is busy with the load result.
    logic              pend_q, pend_d;
    logic              pend_regwrite_q, pend_regwrite_d;
    logic [REG_AW-1:0] pend_rd_q, pend_rd_d;
    logic [DATA_W-1:0] pend_data_q, pend_data_d;

    logic accept, is_mem, in_mem, timeout;

    function automatic logic wb_enable(input logic regwrite, input logic [REG_AW-1:0] rd);
        return regwrite && !((ZERO_REG_HARDWIRED != 0) && (rd == '0));
    endfunction

    assign in_mem   = (state_q == StMem);
    assign ex_ready = !rst && !pend_q && ((state_q == StIdle) || (in_mem && mem_ack));
    assign accept   = ex_valid && ex_ready;
    assign is_mem   = ex_mem_read || ex_mem_write;

    // A combined read+write is treated as a store that writes back the ALU result.
    always_comb begin
        new_op            = '0;
        new_op.regwrite   = ex_regwrite;
        new_op.mem_to_reg = ex_mem_to_reg && !ex_mem_write;
        new_op.we         = ex_mem_write;
        new_op.addr       = MaxDataW'(ex_alu_result);
        new_op.wdata      = MaxDataW'(ex_store_data);
        new_op.rd         = MaxRegAw'(ex_rd);
    end

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk_i     (clk),
        .rst_i     (rst),
        .clear_i   (accept && is_mem),
        .enable_i  (in_mem && !mem_ack),
        .timeout_o (timeout)
    );

    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        wb_regwrite_d   = 1'b0;
        wb_rd_d         = wb_rd_q;
        wb_data_d       = wb_data_q;
        mem_err_d       = mem_err_q;
        retired_d       = retired_q;
        pend_d          = pend_q;
        pend_regwrite_d = pend_regwrite_q;
        pend_rd_d       = pend_rd_q;
        pend_data_d     = pend_data_q;

        unique case (state_q)
            StIdle: begin
                if (pend_q) begin
                    wb_regwrite_d = wb_enable(pend_regwrite_q, pend_rd_q);
                    wb_rd_d       = pend_rd_q;
                    wb_data_d     = pend_data_q;
                    retired_d     = retired_q + CNT_W'(1);
                    pend_d        = 1'b0;
                end else if (accept) begin
                    if (is_mem) begin
                        state_d = StMem;
                        op_d    = new_op;
                    end else begin
                        wb_regwrite_d = wb_enable(ex_regwrite, ex_rd);
                        wb_rd_d       = ex_rd;
                        wb_data_d     = ex_alu_result;
                        retired_d     = retired_q + CNT_W'(1);
                    end
                end
            end
            StMem: begin
                if (mem_ack) begin
                    wb_regwrite_d = wb_enable(op_q.regwrite, op_q.rd[REG_AW-1:0]);
                    wb_rd_d       = op_q.rd[REG_AW-1:0];
                    wb_data_d     = op_q.mem_to_reg ? mem_rdata : op_q.addr[DATA_W-1:0];
                    retired_d     = retired_q + CNT_W'(1);
                    state_d       = StIdle;
                    if (accept) begin
                        if (is_mem) begin
                            state_d = StMem;
                            op_d    = new_op;
                        end else begin
                            pend_d          = 1'b1;
                            pend_regwrite_d = ex_regwrite;
                            pend_rd_d       = ex_rd;
                            pend_data_d     = ex_alu_result;
                        end
                    end
                end else if (timeout) begin
                    state_d   = StIdle;
                    mem_err_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            op_q            <= '0;
            wb_regwrite_q   <= 1'b0;
            wb_rd_q         <= '0;
            wb_data_q       <= '0;
            mem_err_q       <= 1'b0;
            retired_q       <= '0;
            pend_q          <= 1'b0;
            pend_regwrite_q <= 1'b0;
            pend_rd_q       <= '0;
            pend_data_q     <= '0;
        end else begin
            state_q         <= state_d;
            op_q            <= op_d;
            wb_regwrite_q   <= wb_regwrite_d;
            wb_rd_q         <= wb_rd_d;
            wb_data_q       <= wb_data_d;
            mem_err_q       <= mem_err_d;
            retired_q       <= retired_d;
            pend_q          <= pend_d;
            pend_regwrite_q <= pend_regwrite_d;
            pend_rd_q       <= pend_rd_d;
            pend_data_q     <= pend_data_d;
        end
    end

    assign mem_req     = in_mem;
    assign mem_we      = op_q.we;
    assign mem_addr    = op_q.addr[DATA_W-1:0];
    assign mem_wdata   = op_q.wdata[DATA_W-1:0];
    assign wb_regwrite = wb_regwrite_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign mem_err     = mem_err_q;
    assign retired_cnt = retired_q;

    // Bits above the configured widths are always zero.
    logic unused_op_bits;
    assign unused_op_bits = ^{op_q.addr, op_q.wdata, op_q.rd};

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed self-checking bench for mem_wb_pipe (ZERO_REG_HARDWIRED=1, MAX_WAIT=15).
module tb_mem_wb_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       ex_valid, ex_ready, ex_regwrite, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic [7:0] ex_alu_result, ex_store_data;
    logic [2:0] ex_rd;
    logic       mem_req, mem_we, mem_ack;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       wb_regwrite;
    logic [2:0] wb_rd;
    logic [7:0] wb_data;
    logic       mem_err;
    logic [15:0] retired_cnt;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_cnt = '0;

    always #5 clk = ~clk;

    mem_wb_pipe #(
        .DATA_W             (8),
        .REG_AW             (3),
        .MAX_WAIT           (15),
        .CNT_W              (16),
        .ZERO_REG_HARDWIRED (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_regwrite   (ex_regwrite),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_alu_result (ex_alu_result),
        .ex_store_data (ex_store_data),
        .ex_rd         (ex_rd),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .wb_regwrite   (wb_regwrite),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .mem_err       (mem_err),
        .retired_cnt   (retired_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid = 0; ex_regwrite = 0; ex_mem_read = 0; ex_mem_write = 0; ex_mem_to_reg = 0;
        ex_alu_result = '0; ex_store_data = '0; ex_rd = '0; mem_ack = 0; mem_rdata = '0;
    endtask

    task automatic present(input logic rw, input logic mr, input logic mw, input logic m2r,
                           input logic [2:0] rd, input logic [7:0] alu, input logic [7:0] sd);
        ex_valid = 1; ex_regwrite = rw; ex_mem_read = mr; ex_mem_write = mw;
        ex_mem_to_reg = m2r; ex_rd = rd; ex_alu_result = alu; ex_store_data = sd;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick(); tick();
        checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b exp 0", ex_ready); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", mem_req); end
        checks++; if (wb_regwrite !== 1'b0 || wb_rd !== 3'd0 || wb_data !== 8'h00) begin
            errors++; $display("FAIL reset_wb: got %b/%h/%h exp 0/0/00", wb_regwrite, wb_rd, wb_data); end
        checks++; if (mem_err !== 1'b0 || retired_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_err_cnt: got %b/%0d exp 0/0", mem_err, retired_cnt); end
        rst = 0;
        #1;
        checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b exp 1", ex_ready); end
    endtask

    task automatic test_alu_op();
        present(1, 0, 0, 0, 3'd3, 8'h5A, 8'h00);
        tick(); idle_inputs(); exp_cnt++;
        checks++; if (wb_regwrite !== 1'b1 || wb_rd !== 3'd3 || wb_data !== 8'h5A) begin
            errors++; $display("FAIL alu_wb: got %b/%0d/%h exp 1/3/5a", wb_regwrite, wb_rd, wb_data); end
        checks++; if (retired_cnt !== exp_cnt) begin
            errors++; $display("FAIL alu_cnt: got %0d exp %0d", retired_cnt, exp_cnt); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL alu_req: got %b exp 0", mem_req); end
        tick();
        checks++; if (wb_regwrite !== 1'b0 || wb_data !== 8'h5A) begin
            errors++; $display("FAIL alu_hold: got %b/%h exp 0/5a", wb_regwrite, wb_data); end
    endtask

    task automatic test_load();
        present(1, 1, 0, 1, 3'd5, 8'h40, 8'h00);
        tick(); idle_inputs();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin mem_ack = 1; mem_rdata = 8'hC3; end
            #1;
            checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h40) begin
                errors++; $display("FAIL load_req[%0d]: got %b/%b/%h exp 1/0/40", i, mem_req, mem_we, mem_addr); end
            checks++; if (ex_ready !== (i == 2)) begin
                errors++; $display("FAIL load_ready[%0d]: got %b exp %b", i, ex_ready, i == 2); end
            checks++; if (wb_regwrite !== 1'b0) begin
                errors++; $display("FAIL load_early_wb[%0d]: got %b exp 0", i, wb_regwrite); end
            tick();
        end
        idle_inputs(); exp_cnt++;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL load_req_drop: got %b exp 0", mem_req); end
        checks++; if (wb_regwrite !== 1'b1 || wb_rd !== 3'd5 || wb_data !== 8'hC3) begin
            errors++; $display("FAIL load_wb: got %b/%0d/%h exp 1/5/c3", wb_regwrite, wb_rd, wb_data); end
        checks++; if (retired_cnt !== exp_cnt) begin
            errors++; $display("FAIL load_cnt: got %0d exp %0d", retired_cnt, exp_cnt); end
        tick();
        checks++; if (wb_regwrite !== 1'b0) begin errors++; $display("FAIL load_single_pulse: got %b exp 0", wb_regwrite); end
    endtask

    task automatic test_store();
        present(0, 0, 1, 0, 3'd2, 8'h10, 8'h77);
        tick(); idle_inputs();
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h10 || mem_wdata !== 8'h77) begin
            errors++; $display("FAIL store_req: got %b/%b/%h/%h exp 1/1/10/77", mem_req, mem_we, mem_addr, mem_wdata); end
        mem_ack = 1; mem_rdata = 8'hEE;
        tick(); idle_inputs(); exp_cnt++;
        checks++; if (mem_req !== 1'b0 || wb_regwrite !== 1'b0) begin
            errors++; $display("FAIL store_done: got req %b wb %b exp 0/0", mem_req, wb_regwrite); end
        checks++; if (wb_rd !== 3'd2 || wb_data !== 8'h10) begin
            errors++; $display("FAIL store_wbdata: got %0d/%h exp 2/10", wb_rd, wb_data); end
        checks++; if (retired_cnt !== exp_cnt) begin
            errors++; $display("FAIL store_cnt: got %0d exp %0d", retired_cnt, exp_cnt); end
    endtask

    task automatic test_read_write_both();
        present(1, 1, 1, 1, 3'd7, 8'h33, 8'h44);
        tick(); idle_inputs();
        checks++; if (mem_we !== 1'b1 || mem_wdata !== 8'h44) begin
            errors++; $display("FAIL rw_we: got %b/%h exp 1/44", mem_we, mem_wdata); end
        mem_ack = 1; mem_rdata = 8'hAA;
        tick(); idle_inputs(); exp_cnt++;
        checks++; if (wb_regwrite !== 1'b1 || wb_rd !== 3'd7 || wb_data !== 8'h33) begin
            errors++; $display("FAIL rw_wb: got %b/%0d/%h exp 1/7/33", wb_regwrite, wb_rd, wb_data); end
    endtask

    task automatic test_back_to_back();
        present(1, 1, 0, 1, 3'd1, 8'h20, 8'h00);
        tick(); idle_inputs();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h20) begin
            errors++; $display("FAIL b2b_first: got %b/%h exp 1/20", mem_req, mem_addr); end
        mem_ack = 1; mem_rdata = 8'h11;
        present(1, 1, 0, 1, 3'd4, 8'h30, 8'h00);
        checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b exp 1", ex_ready); end
        tick(); idle_inputs(); exp_cnt++;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h30) begin
            errors++; $display("FAIL b2b_second: got %b/%h exp 1/30", mem_req, mem_addr); end
        checks++; if (wb_regwrite !== 1'b1 || wb_rd !== 3'd1 || wb_data !== 8'h11) begin
            errors++; $display("FAIL b2b_wb1: got %b/%0d/%h exp 1/1/11", wb_regwrite, wb_rd, wb_data); end
        mem_ack = 1; mem_rdata = 8'h22;
        tick(); idle_inputs(); exp_cnt++;
        checks++; if (mem_req !== 1'b0 || wb_regwrite !== 1'b1 || wb_rd !== 3'd4 || wb_data !== 8'h22) begin
            errors++; $display("FAIL b2b_wb2: got %b/%b/%0d/%h exp 0/1/4/22", mem_req, wb_regwrite, wb_rd, wb_data); end
        checks++; if (retired_cnt !== exp_cnt) begin
            errors++; $display("FAIL b2b_cnt: got %0d exp %0d", retired_cnt, exp_cnt); end
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        int wb_pulses = 0;
        present(1, 1, 0, 1, 3'd6, 8'h50, 8'h00);
        tick(); idle_inputs();
        for (int i = 0; i < 15; i++) begin
            if (mem_req === 1'b1 && ex_ready === 1'b0) req_cycles++;
            if (wb_regwrite !== 1'b0) wb_pulses++;
            tick();
        end
        checks++; if (req_cycles != 15) begin errors++; $display("FAIL to_req_cycles: got %0d exp 15", req_cycles); end
        checks++; if (wb_pulses != 0) begin errors++; $display("FAIL to_wb_during: got %0d exp 0", wb_pulses); end
        checks++; if (mem_req !== 1'b0 || mem_err !== 1'b1 || wb_regwrite !== 1'b0) begin
            errors++; $display("FAIL to_abort: got req %b err %b wb %b exp 0/1/0", mem_req, mem_err, wb_regwrite); end
        checks++; if (retired_cnt !== exp_cnt || ex_ready !== 1'b1) begin
            errors++; $display("FAIL to_cnt_ready: got %0d/%b exp %0d/1", retired_cnt, ex_ready, exp_cnt); end
        tick();
        checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b exp 1", mem_err); end
    endtask

    task automatic test_reset_mid_mem();
        present(1, 1, 0, 1, 3'd2, 8'h60, 8'h00);
        tick(); idle_inputs(); tick(); tick();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rmm_req: got %b exp 1", mem_req); end
        rst = 1;
        tick();
        rst = 0; exp_cnt = '0;
        checks++; if (mem_req !== 1'b0 || mem_addr !== 8'h00 || mem_err !== 1'b0 || retired_cnt !== 16'd0) begin
            errors++; $display("FAIL rmm_cleared: got %b/%h/%b/%0d exp 0/00/0/0", mem_req, mem_addr, mem_err, retired_cnt); end
        mem_ack = 1; mem_rdata = 8'h5C;
        tick(); idle_inputs();
        checks++; if (wb_regwrite !== 1'b0 || retired_cnt !== 16'd0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL rmm_late_ack: got wb %b cnt %0d req %b exp 0/0/0", wb_regwrite, retired_cnt, mem_req); end
    endtask

    task automatic test_zero_reg();
        present(1, 0, 0, 0, 3'd0, 8'h99, 8'h00);
        tick(); idle_inputs(); exp_cnt++;
        checks++; if (wb_regwrite !== 1'b0) begin errors++; $display("FAIL zr_suppress: got %b exp 0", wb_regwrite); end
        checks++; if (retired_cnt !== exp_cnt || wb_data !== 8'h99) begin
            errors++; $display("FAIL zr_retire: got %0d/%h exp %0d/99", retired_cnt, wb_data, exp_cnt); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alu_op();
        test_load();
        test_store();
        test_read_write_both();
        test_back_to_back();
        test_timeout();
        test_reset_mid_mem();
        test_zero_reg();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
